// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache-line to burst adaptor.
package cacheline_adaptor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        READ_DONE,
        WRITE,
        WRITE_DONE
    } state_t;

    localparam int BEATS  = 4;
    localparam int BEAT_W = 64;

endpackage

// File: rtl/cacheline_adaptor_line_buffer.sv
// Beat storage: a write line loaded whole and sliced out per beat, and a read
// line assembled one beat at a time. Kept separate so a write never disturbs read data.
module line_buffer #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int IDX_W  = $clog2(LINE_W / BEAT_W)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load_line,
    input  logic [LINE_W-1:0] line_in,
    input  logic              load_beat,
    input  logic [BEAT_W-1:0] beat_in,
    input  logic [IDX_W-1:0]  index,
    output logic [LINE_W-1:0] line_out,
    output logic [BEAT_W-1:0] beat_out
);

    localparam int N = LINE_W / BEAT_W;

    logic [BEAT_W-1:0] wr_beats [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            logic [BEAT_W-1:0] wr_slot_reg;
            logic [BEAT_W-1:0] rd_slot_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    wr_slot_reg <= '0;
                    rd_slot_reg <= '0;
                end else begin
                    if (load_line)
                        wr_slot_reg <= line_in[gi*BEAT_W +: BEAT_W];
                    if (load_beat && index == IDX_W'(gi))
                        rd_slot_reg <= beat_in;
                end
            end

            assign wr_beats[gi]                   = wr_slot_reg;
            assign line_out[gi*BEAT_W +: BEAT_W] = rd_slot_reg;
        end
    endgenerate

    assign beat_out = wr_beats[index];

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts single-cycle cache line requests into multi-beat memory bursts.
// Requests are only sampled in IDLE; the beat counter indexes the line buffer.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_burst  = BEAT_W
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [31:0]        pmem_address,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [s_line-1:0]  pmem_wdata256,
    output logic [s_line-1:0]  pmem_rdata256,
    output logic               pmem_resp,

    output logic [31:0]        burst_address,
    output logic               burst_read,
    output logic               burst_write,
    output logic [s_burst-1:0] burst_wdata,
    input  logic [s_burst-1:0] burst_rdata,
    input  logic               burst_resp
);

    localparam int N_BEATS = s_line / s_burst;
    localparam int CNT_W   = $clog2(N_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(N_BEATS - 1);
    localparam logic [31:0]      ALIGN_MASK = ~((32'd1 << s_offset) - 32'd1);

    state_t            state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [31:0]       addr_reg;
    logic [s_burst-1:0] wr_beat;
    logic              load_line;
    logic              load_beat;

    assign load_line = (state_reg == IDLE) && !pmem_read && pmem_write;
    assign load_beat = (state_reg == READ) && burst_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            addr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    count_reg <= '0;
                    // Read wins when both requests are present.
                    if (pmem_read) begin
                        addr_reg  <= pmem_address;
                        state_reg <= READ;
                    end else if (pmem_write) begin
                        addr_reg  <= pmem_address;
                        state_reg <= WRITE;
                    end
                end
                READ, WRITE: begin
                    if (burst_resp) begin
                        if (count_reg == LAST_BEAT) begin
                            count_reg <= '0;
                            state_reg <= (state_reg == READ) ? READ_DONE : WRITE_DONE;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                READ_DONE, WRITE_DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    line_buffer #(
        .LINE_W (s_line),
        .BEAT_W (s_burst),
        .IDX_W  (CNT_W)
    ) u_line_buffer (
        .clk       (clk),
        .srst      (rst),
        .load_line (load_line),
        .line_in   (pmem_wdata256),
        .load_beat (load_beat),
        .beat_in   (burst_rdata),
        .index     (count_reg),
        .line_out  (pmem_rdata256),
        .beat_out  (wr_beat)
    );

    assign burst_read    = (state_reg == READ);
    assign burst_write   = (state_reg == WRITE);
    assign pmem_resp     = (state_reg == READ_DONE) || (state_reg == WRITE_DONE);
    assign burst_address = (burst_read || burst_write) ? (addr_reg & ALIGN_MASK) : 32'd0;
    assign burst_wdata   = burst_write ? wr_beat : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor: read, write, gapped read,
// read/write collision, mid-read reset and spurious burst responses.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata256;
    logic [255:0] pmem_rdata256;
    logic         pmem_resp;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int n_checks = 0;
    int n_fail   = 0;

    cacheline_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_address  (pmem_address),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_wdata256 (pmem_wdata256),
        .pmem_rdata256 (pmem_rdata256),
        .pmem_resp     (pmem_resp),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one read; the cycle of the request is cycle 1. Returns on the
    // pmem_resp cycle (or after a bounded wait, with resp_cycle = -1).
    task automatic run_read(input logic [31:0] addr, input logic [255:0] line,
                            input int gap, input logic also_write,
                            output int resp_cycle, output logic [31:0] baddr,
                            output logic bw_seen, output logic br_drop);
        int cyc;
        cyc = 1;
        bw_seen = 1'b0;
        br_drop = 1'b0;
        resp_cycle = -1;
        pmem_address = addr;
        pmem_read    = 1'b1;
        pmem_write   = also_write;
        step();
        cyc++;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_address = 32'hFFFF_FFFF;
        baddr = burst_address;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                for (int g = 0; g < gap; g++) begin
                    burst_resp = 1'b0;
                    burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                    bw_seen |= burst_write;
                    br_drop |= !burst_read;
                    step();
                    cyc++;
                end
            end
            burst_resp  = 1'b1;
            burst_rdata = line[b*64 +: 64];
            bw_seen |= burst_write;
            br_drop |= !burst_read;
            step();
            cyc++;
        end
        burst_resp  = 1'b0;
        burst_rdata = 64'h0;
        for (int k = 0; k < 5; k++) begin
            bw_seen |= burst_write;
            if (pmem_resp) begin
                resp_cycle = cyc;
                break;
            end
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({pmem_resp, burst_read, burst_write} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000", {pmem_resp, burst_read, burst_write});
        end
        n_checks++;
        if (pmem_rdata256 !== 256'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 0", pmem_rdata256);
        end
        n_checks++;
        if ({burst_address, burst_wdata} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr %h wdata %h expected 0", burst_address, burst_wdata);
        end
        rst = 1'b0;
        step();
        $display("reset transaction done");
    endtask

    task automatic test_read();
        logic [255:0] line;
        int rc;
        logic [31:0] ba;
        logic bw, bd;
        line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        run_read(32'h0000_1234, line, 0, 1'b0, rc, ba, bw, bd);
        n_checks++;
        if (ba !== 32'h0000_1220) begin
            n_fail++;
            $display("FAIL read_addr: got %h expected 00001220", ba);
        end
        n_checks++;
        if (rc !== 6) begin
            n_fail++;
            $display("FAIL read_latency: got %0d expected 6", rc);
        end
        n_checks++;
        if (pmem_rdata256 !== line) begin
            n_fail++;
            $display("FAIL read_line: got %h expected %h", pmem_rdata256, line);
        end
        n_checks++;
        if (burst_wdata !== 64'h0) begin
            n_fail++;
            $display("FAIL read_wdata_zero: got %h expected 0", burst_wdata);
        end
        step();
        n_checks++;
        if (pmem_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL read_resp_pulse: got %b expected 0", pmem_resp);
        end
        n_checks++;
        if (pmem_rdata256 !== line) begin
            n_fail++;
            $display("FAIL read_hold: got %h expected %h", pmem_rdata256, line);
        end
        $display("read addr=%h resp_cycle=%0d line=%h", ba, rc, pmem_rdata256);
    endtask

    task automatic test_write();
        logic [63:0] d [4];
        logic [255:0] prev_rd;
        int waited;
        d[0] = 64'hD0D0_0000_0000_00D0;
        d[1] = 64'hD1D1_1111_1111_11D1;
        d[2] = 64'hD2D2_2222_2222_22D2;
        d[3] = 64'hD3D3_3333_3333_33D3;
        prev_rd = pmem_rdata256;
        pmem_address  = 32'hABCD_EF7F;
        pmem_wdata256 = {d[3], d[2], d[1], d[0]};
        pmem_write    = 1'b1;
        step();
        pmem_write    = 1'b0;
        pmem_wdata256 = '1;
        n_checks++;
        if ({burst_write, burst_read} !== 2'b10) begin
            n_fail++;
            $display("FAIL write_ctrl: got %b expected 10", {burst_write, burst_read});
        end
        n_checks++;
        if (burst_address !== 32'hABCD_EF60) begin
            n_fail++;
            $display("FAIL write_addr: got %h expected abcdef60", burst_address);
        end
        for (int b = 0; b < 4; b++) begin
            burst_resp = 1'b0;
            step();
            n_checks++;
            if (burst_wdata !== d[b]) begin
                n_fail++;
                $display("FAIL write_hold_beat%0d: got %h expected %h", b, burst_wdata, d[b]);
            end
            burst_resp = 1'b1;
            #1;
            n_checks++;
            if (burst_wdata !== d[b]) begin
                n_fail++;
                $display("FAIL write_beat%0d: got %h expected %h", b, burst_wdata, d[b]);
            end
            step();
        end
        burst_resp = 1'b0;
        waited = 0;
        while (!pmem_resp && waited < 5) begin
            step();
            waited++;
        end
        n_checks++;
        if (waited !== 0) begin
            n_fail++;
            $display("FAIL write_latency: got %0d extra cycles expected 0", waited);
        end
        n_checks++;
        if ({burst_write, burst_wdata} !== 65'h0) begin
            n_fail++;
            $display("FAIL write_done_bus: got %b/%h expected 0/0", burst_write, burst_wdata);
        end
        n_checks++;
        if (pmem_rdata256 !== prev_rd) begin
            n_fail++;
            $display("FAIL write_rdata_hold: got %h expected %h", pmem_rdata256, prev_rd);
        end
        step();
        n_checks++;
        if (pmem_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL write_resp_pulse: got %b expected 0", pmem_resp);
        end
        $display("write addr=abcdef7f extra_wait=%0d", waited);
    endtask

    task automatic test_gapped_read();
        logic [255:0] line;
        int rc;
        logic [31:0] ba;
        logic bw, bd;
        line = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'hA5A5_5A5A_A5A5_5A5A, 64'h0F0F_F0F0_0F0F_F0F0};
        run_read(32'h8000_003F, line, 2, 1'b0, rc, ba, bw, bd);
        n_checks++;
        if (rc !== 8) begin
            n_fail++;
            $display("FAIL gap_latency: got %0d expected 8", rc);
        end
        n_checks++;
        if (bd !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_burst_read: got drop=%b expected 0", bd);
        end
        n_checks++;
        if (pmem_rdata256 !== line) begin
            n_fail++;
            $display("FAIL gap_line: got %h expected %h", pmem_rdata256, line);
        end
        n_checks++;
        if (ba !== 32'h8000_0020) begin
            n_fail++;
            $display("FAIL gap_addr: got %h expected 80000020", ba);
        end
        step();
        $display("gapped read addr=%h resp_cycle=%0d", ba, rc);
    endtask

    task automatic test_read_write_collision();
        logic [255:0] line;
        int rc;
        logic [31:0] ba;
        logic bw, bd;
        line = {64'h1000_0000_0000_0004, 64'h1000_0000_0000_0003,
                64'h1000_0000_0000_0002, 64'h1000_0000_0000_0001};
        pmem_wdata256 = {4{64'hBAD0_BAD0_BAD0_BAD0}};
        run_read(32'h0000_0040, line, 0, 1'b1, rc, ba, bw, bd);
        n_checks++;
        if (bw !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_write_seen: got %b expected 0", bw);
        end
        n_checks++;
        if (bd !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_read: got drop=%b expected 0", bd);
        end
        n_checks++;
        if (pmem_rdata256 !== line || rc !== 6) begin
            n_fail++;
            $display("FAIL collide_line: got %h cyc %0d expected %h cyc 6", pmem_rdata256, rc, line);
        end
        step();
        $display("collision read addr=%h resp_cycle=%0d", ba, rc);
    endtask

    task automatic test_reset_mid_read();
        logic [255:0] line;
        int rc;
        logic [31:0] ba;
        logic bw, bd;
        logic resp_seen;
        resp_seen = 1'b0;
        pmem_address = 32'h0000_2000;
        pmem_read = 1'b1;
        step();
        pmem_read = 1'b0;
        for (int b = 0; b < 2; b++) begin
            burst_resp  = 1'b1;
            burst_rdata = 64'h7777_0000_0000_0000 | 64'(b);
            step();
        end
        burst_resp = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({pmem_resp, burst_read, burst_write, burst_address, burst_wdata} !== 99'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got resp=%b rd=%b wr=%b addr=%h wdata=%h expected all 0",
                     pmem_resp, burst_read, burst_write, burst_address, burst_wdata);
        end
        n_checks++;
        if (pmem_rdata256 !== 256'h0) begin
            n_fail++;
            $display("FAIL midreset_rdata: got %h expected 0", pmem_rdata256);
        end
        for (int k = 0; k < 4; k++) begin
            burst_resp = 1'b1;
            burst_rdata = 64'hEEEE_EEEE_EEEE_EEEE;
            step();
            resp_seen |= pmem_resp | burst_read | burst_write;
        end
        burst_resp = 1'b0;
        n_checks++;
        if (resp_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_abort: got activity=%b expected 0", resp_seen);
        end
        line = {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};
        run_read(32'h0000_2004, line, 0, 1'b0, rc, ba, bw, bd);
        n_checks++;
        if (pmem_rdata256 !== line || rc !== 6) begin
            n_fail++;
            $display("FAIL midreset_fresh_read: got %h cyc %0d expected %h cyc 6", pmem_rdata256, rc, line);
        end
        step();
        $display("mid-read reset then read addr=%h resp_cycle=%0d", ba, rc);
    endtask

    task automatic test_spurious_idle_resp();
        logic [255:0] line;
        int rc;
        logic [31:0] ba;
        logic bw, bd;
        logic activity;
        activity = 1'b0;
        for (int k = 0; k < 3; k++) begin
            burst_resp = 1'b1;
            burst_rdata = 64'h9999_9999_9999_9999;
            step();
            activity |= pmem_resp | burst_read | burst_write;
        end
        burst_resp = 1'b0;
        n_checks++;
        if (activity !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_state: got activity=%b expected 0", activity);
        end
        line = {64'h0000_0000_0000_0D04, 64'h0000_0000_0000_0C03,
                64'h0000_0000_0000_0B02, 64'h0000_0000_0000_0A01};
        run_read(32'h0000_0100, line, 0, 1'b0, rc, ba, bw, bd);
        n_checks++;
        if (pmem_rdata256 !== line || rc !== 6) begin
            n_fail++;
            $display("FAIL spurious_count: got %h cyc %0d expected %h cyc 6", pmem_rdata256, rc, line);
        end
        step();
        $display("spurious idle resp then read addr=%h resp_cycle=%0d", ba, rc);
    endtask

    initial begin
        rst           = 1'b1;
        pmem_address  = 32'h0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_wdata256 = '0;
        burst_rdata   = 64'h0;
        burst_resp    = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_gapped_read();
        test_read_write_collision();
        test_reset_mid_read();
        test_spurious_idle_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
